fir_mac_param: RTL and testbench
================================

// Module: fir_mac_param
// PURPOSE
//  Parametrised, coefficient-programmable FIR filter using one time-multiplexed multiply-accumulate unit.
//  Successor to the fixed 8-tap/16-bit filter, adding:
//   - ready/valid input handshake
//   - runtime coefficient load
//   - output scaling
//   - optional round/saturate
//  Sits between the sample source and the downstream DSP chain; one sample in, one filtered sample out.
// PARAMETERS
//  DATA_W    16                            signed input sample width
//  COEF_W    16                            signed coefficient width
//  TAPS      8                             number of taps (>=2)
//  ACC_W     DATA_W+COEF_W+$clog2(TAPS)    accumulator width (no internal overflow)
//  OUT_W     32                            signed output width
//  OUT_SHIFT 0                             arithmetic right shift applied to acc before output
// PORTS
//  clk        in   1                clock, all logic rising-edge
//  reset      in   1                synchronous, active-high
//  in_valid   in   1                sample offered
//  in_ready   out  1                block can accept a sample this cycle
//  in_data    in   DATA_W           signed sample
//  coef_we    in   1                coefficient write strobe
//  coef_addr  in   $clog2(TAPS)     tap index to write
//  coef_data  in   COEF_W           signed coefficient value
//  out_valid  out  1                one-cycle pulse, out_data holds new result
//  out_data   out  OUT_W            signed filtered sample
//  busy       out  1                high while in MAC state
// BEHAVIOUR
//  Reset (reset sampled high at posedge):
//   - state=IDLE; delay line all 0; acc=0; tap counter=0
//   - coef[i]=i+1 (1..TAPS); out_valid=0; out_data=0
//   - in_ready=0 and busy=0 while reset is high
//  FSM states IDLE, MAC, OUT:
//   - in_ready = (state==IDLE || state==OUT) && !reset; busy = (state==MAC)
//   - Accept = in_valid && in_ready: shift line (x[i]<=x[i-1], x[0]<=in_data), acc<=0, k<=0, go MAC
//   - IDLE: no accept -> stay
//   - MAC: each cycle acc <= acc + x[k]*coef[k] (full-precision signed product, sign-extended to ACC_W); k++
//   - MAC: after k==TAPS-1 MAC cycle -> OUT
//   - OUT: out_valid=1 for exactly this cycle; out_data updated; accept -> MAC, else -> IDLE
//  Timing:
//   - Latency: out_valid is high TAPS+1 cycles after the accept edge
//   - Sustained throughput: one sample per TAPS+1 cycles
//   - in_valid held while in_ready=0 is not consumed; the data must stay stable
//  Output:
//   - out_data holds its value between out_valid pulses
//   - Scaled result = acc >>> OUT_SHIFT (arithmetic), then width-adjusted per CONFIGURATION
//  Coefficients:
//   - coef_we honoured in IDLE and OUT; value visible from the next cycle
//   - coef_we during MAC is ignored, so a filtered sample never mixes old and new coefficients
//   - coef_we during reset is ignored
//  Simultaneous accept + coef_we in OUT: both take effect; new sample's MAC uses the new coefficient
//  Reset mid-MAC: computation discarded, no out_valid, all state as reset
// CONFIGURATION
//  FIR_SAT_EN defined:
//   - if OUT_SHIFT>0 add 1<<(OUT_SHIFT-1) before shift (round half up)
//   - clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//  FIR_SAT_EN undefined:
//   - plain arithmetic shift (truncate toward -inf)
//   - keep low OUT_W bits, wrapping on overflow, or sign-extend if OUT_W > ACC_W
// TESTING
//  1 Impulse, default coefs: in 1 then seven 0s -> out 1,2,3,4,5,6,7,8, then 0
//  2 Step, default coefs: in 100 repeated -> out 100,300,600,...,3600, then 3600 steady
//  3 Coef load: write coef[0..7]=-1, in 1000 after reset -> out -1000
//  4 coef_we=1, coef[0]=50 issued mid-MAC -> ignored; current and next output unchanged
//  5 Back-to-back: in_valid held high with 20 samples -> in_ready high only in IDLE/OUT
//    - accepts spaced TAPS+1=9 cycles
//    - each out_valid exactly 9 cycles after its accept
//    - no sample lost or duplicated
//  6 Reset mid-MAC: assert reset at MAC cycle 3 -> no out_valid
//    - coefs back to 1..8
//    - next impulse reproduces scenario 1
//  7 OUT_W=16, all coefs 32767, in 32767 x8:
//    - FIR_SAT_EN defined -> 32767
//    - FIR_SAT_EN undefined -> 8 (wrapped low bits)

Source files
------------

// File: rtl/fir_mac_param.sv
// FIR filter with runtime-loadable coefficients and one time-shared multiply-accumulate unit.
// Define FIR_SAT_EN for round-half-up plus output saturation; otherwise the output is shifted, truncated and wrapped.
module fir_mac_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy,
  output logic [1:0]              dbg_state
);
  localparam int K_W    = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int EXT_W  = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        x_q [TAPS];
  logic [COEF_W-1:0]        coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     accept;
  logic                     coef_wr_en;
  logic                     last_tap;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [EXT_W-1:0]  ext;
  logic [OUT_W-1:0]         scaled;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready; the source
  // keeps in_data stable while in_valid is high and in_ready is low.
  assign in_ready   = ((state_q == S_IDLE) || (state_q == S_OUT)) && !reset;
  assign busy       = (state_q == S_MAC) && !reset;
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = out_data_q;
  assign dbg_state  = state_q;
  assign accept     = in_valid && in_ready;
  // Coefficients only change outside MAC, so one result never mixes old and new taps.
  assign coef_wr_en = coef_we && in_ready;
  assign last_tap   = (k_q == K_W'(TAPS - 1));

  assign prod    = $signed(x_q[k_q]) * $signed(coef_q[k_q]);
  assign mac_sum = acc_q + ACC_W'(prod);
  assign ext     = EXT_W'(mac_sum);

`ifdef FIR_SAT_EN
  localparam logic signed [EXT_W-1:0] RND =
    (OUT_SHIFT > 0) ? (EXT_W'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    shifted = (ext + RND) >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      scaled = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      scaled = SAT_MIN[OUT_W-1:0];
    end else begin
      scaled = shifted[OUT_W-1:0];
    end
  end
`else
  // EXT_W exceeds OUT_W, so this both sign-extends and wraps as needed.
  assign scaled = OUT_W'(ext >>> OUT_SHIFT);
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE, S_OUT: begin
        if (accept) begin
          state_d = S_MAC;
          acc_d   = '0;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = mac_sum;
        k_d   = k_q + K_W'(1);
        if (last_tap) begin
          state_d    = S_OUT;
          k_d        = '0;
          out_data_d = scaled;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      out_data_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= COEF_W'(i + 1);
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
      if (accept) begin
        x_q[0] <= in_data;
        for (int i = 1; i < TAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      if (coef_wr_en) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// Bench for fir_mac_param: three instances (default, 16-bit output, shifted output) share one stimulus
// stream and are checked against a sample-level dot-product model; FIR_SAT_EN selects expected scaling.
module tb_fir_mac_param;
  localparam int TAPS = 8;
  localparam int SH2  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [31:0] od0, od2;
  logic [15:0] od1;
  logic [1:0]  st0, st1, st2;

  fir_mac_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov0), .out_data(od0), .busy(bz0), .dbg_state(st0)
  );

  fir_mac_param #(.OUT_W(16)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov1), .out_data(od1), .busy(bz1), .dbg_state(st1)
  );

  fir_mac_param #(.OUT_SHIFT(SH2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov2), .out_data(od2), .busy(bz2), .dbg_state(st2)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  longint      m_hist [TAPS];
  longint      m_coef [TAPS];
  int          busy_cnt = 0;
  longint      pend_acc[$];
  int          pend_due[$];
  logic [79:0] exp_q[$];
  logic [79:0] obs_q[$];
  logic [79:0] hold = '0;
  logic [79:0] exp_word;
  int          mcyc = 0;
  int          proto_err = 0;
  int          total = 0;
  int          bad = 0;
  logic        exp_ov, m_ready, m_busy;
  longint      mon_acc;

  function automatic longint scale(input longint acc, input int sh, input int ow);
    longint v;
    longint lim;
`ifdef FIR_SAT_EN
    v = acc;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    lim = longint'(1) << (ow - 1);
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
`else
    v = acc >>> sh;
    lim = longint'(1) << ow;
    v = v & (lim - 1);
    if (v >= lim / 2) v = v - lim;
`endif
    return v;
  endfunction

  // Observes just after each falling edge, then advances the model for the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    mcyc++;
    exp_ov = (pend_due.size() > 0) && (pend_due[0] == mcyc);
    if (exp_ov) begin
      mon_acc = pend_acc.pop_front();
      void'(pend_due.pop_front());
      exp_word = {32'(scale(mon_acc, 0, 32)), 16'(scale(mon_acc, 0, 16)), 32'(scale(mon_acc, SH2, 32))};
      hold = exp_word;
      exp_q.push_back(exp_word);
    end
    if (ov0 || ov1 || ov2) obs_q.push_back({od0, od1, od2});
    m_ready = !reset && (busy_cnt == 0);
    m_busy  = !reset && (busy_cnt > 0);
    if ({rdy0, rdy1, rdy2} !== {3{m_ready}} || {bz0, bz1, bz2} !== {3{m_busy}} ||
        {ov0, ov1, ov2} !== {3{exp_ov}} || {od0, od1, od2} !== hold) begin
      proto_err++;
      $display("note: cycle %0d deviation ready=%b%b%b/%b busy=%b%b%b/%b valid=%b%b%b/%b data=%h/%h",
               mcyc, rdy0, rdy1, rdy2, m_ready, bz0, bz1, bz2, m_busy, ov0, ov1, ov2, exp_ov,
               {od0, od1, od2}, hold);
    end
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        m_hist[i] = 0;
        m_coef[i] = i + 1;
      end
      busy_cnt = 0;
      pend_acc.delete();
      pend_due.delete();
      hold = '0;
    end else begin
      if (coef_we && busy_cnt == 0) m_coef[coef_addr] = longint'($signed(coef_data));
      if (busy_cnt > 0) begin
        busy_cnt--;
      end else if (in_valid) begin
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = longint'($signed(in_data));
        mon_acc = 0;
        for (int i = 0; i < TAPS; i++) mon_acc += m_hist[i] * m_coef[i];
        pend_acc.push_back(mon_acc);
        pend_due.push_back(mcyc + TAPS + 1);
        busy_cnt = TAPS;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] d, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    while (!rdy0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] val);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = val;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    coef_we  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({rdy0, rdy1, rdy2, bz0, bz1, bz2, ov0, ov1, ov2} !== 9'b0 || {od0, od1, od2} !== 80'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b%b%b busy=%b%b%b valid=%b%b%b data=%h, required all zero",
               rdy0, rdy1, rdy2, bz0, bz1, bz2, ov0, ov1, ov2, {od0, od1, od2});
    end
    total++;
    if (st0 !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d required 0 (IDLE)", st0);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b required 1", rdy0);
    end
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_impulse(input string tag);
    int w;
    int pe0 = proto_err;
    logic [79:0] o, e;
    logic [31:0] lit;
    send(16'd1, w);
    for (int i = 0; i < 8; i++) send(16'd0, w);
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != 9 || exp_q.size() != 9) begin
      bad++;
      $display("FAIL %s_count: got %0d outputs (model %0d) required 9", tag, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 9 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      lit = (i < 8) ? 32'(i + 1) : 32'd0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s_model[%0d]: got %h required %h", tag, i, o, e);
      end
      total++;
      if (o[79:48] !== lit) begin
        bad++;
        $display("FAIL %s_value[%0d]: got %0d required %0d", tag, i, $signed(o[79:48]), lit);
      end
    end
    total++;
    if (proto_err != pe0) begin
      bad++;
      $display("FAIL %s_timing: got %0d deviations required 0", tag, proto_err - pe0);
    end
  endtask

  task automatic test_step();
    int w;
    int pe0 = proto_err;
    logic [79:0] o, e;
    int k;
    for (int i = 0; i < 11; i++) send(16'd100, w);
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != 11 || exp_q.size() != 11) begin
      bad++;
      $display("FAIL step_count: got %0d outputs (model %0d) required 11", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 11 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      k = (i < 8) ? i + 1 : 8;
      total++;
      if (o !== e || o[79:48] !== 32'(100 * k * (k + 1) / 2)) begin
        bad++;
        $display("FAIL step_value[%0d]: got %h required %h (main %0d)", i, o, e, 100 * k * (k + 1) / 2);
      end
    end
    total++;
    if (proto_err != pe0) begin
      bad++;
      $display("FAIL step_timing: got %0d deviations required 0", proto_err - pe0);
    end
  endtask

  task automatic test_coef_load();
    int w;
    logic [79:0] o, e;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'hFFFF);
    send(16'd1000, w);
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      bad++;
      $display("FAIL coef_load_count: got %0d outputs required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e || o[79:48] !== 32'hFFFF_FC18) begin
        bad++;
        $display("FAIL coef_load_value: got %0d required -1000", $signed(o[79:48]));
      end
    end
  endtask

  task automatic test_coef_mid_mac();
    int w;
    logic [31:0] lit [2];
    logic [79:0] o, e;
    lit[0] = 32'd10;
    lit[1] = 32'd40;
    do_reset();
    send(16'd10, w);
    in_valid = 1'b0;
    @(negedge clk);
    write_coef(3'd0, 16'd50);
    send(16'd20, w);
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      bad++;
      $display("FAIL coef_mid_mac_count: got %0d outputs required 2", obs_q.size());
    end
    for (int i = 0; i < 2 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e || o[79:48] !== lit[i]) begin
        bad++;
        $display("FAIL coef_mid_mac[%0d]: got %0d required %0d", i, $signed(o[79:48]), lit[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int pe0 = proto_err;
    logic [79:0] o, e;
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), w);
      if (i > 0) begin
        total++;
        if (w + 1 != TAPS + 1) begin
          bad++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", i, w + 1, TAPS + 1);
        end
      end
    end
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != 20 || exp_q.size() != 20) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs (model %0d) required 20", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL b2b_value: got %h required %h", o, e);
      end
    end
    total++;
    if (proto_err != pe0) begin
      bad++;
      $display("FAIL b2b_timing: got %0d deviations required 0", proto_err - pe0);
    end
  endtask

  task automatic test_reset_mid_mac();
    int w;
    int pe0 = proto_err;
    do_reset();
    write_coef(3'd0, 16'd7);
    send(16'd1, w);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (rdy0 !== 1'b0 || bz0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_mac_flags: ready=%b busy=%b required 0 0", rdy0, bz0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(TAPS + 4);
    total++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_mac_output: got %0d outputs required 0", obs_q.size());
    end
    total++;
    if (proto_err != pe0) begin
      bad++;
      $display("FAIL reset_mid_mac_timing: got %0d deviations required 0", proto_err - pe0);
    end
    test_impulse("impulse_after_reset");
  endtask

  task automatic test_overflow();
    int w;
    logic [79:0] o, e;
    logic [15:0] lit_n;
`ifdef FIR_SAT_EN
    lit_n = 16'h7FFF;
`else
    lit_n = 16'd8;
`endif
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'h7FFF);
    for (int i = 0; i < 8; i++) send(16'h7FFF, w);
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      bad++;
      $display("FAIL overflow_count: got %0d outputs required 8", obs_q.size());
    end
    for (int i = 0; i < 8 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL overflow_model[%0d]: got %h required %h", i, o, e);
      end
      if (i == 7) begin
        total++;
        if (o[47:32] !== lit_n) begin
          bad++;
          $display("FAIL overflow_out16: got %0d required %0d", $signed(o[47:32]), $signed(lit_n));
        end
      end
    end
  endtask

  task automatic test_random();
    int pe0 = proto_err;
    logic taken = 1'b0;
    logic [79:0] o, e;
    int n = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (taken || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
      end
      coef_we   = ($urandom_range(0, 6) == 0);
      coef_addr = 3'($urandom_range(0, 7));
      coef_data = 16'($urandom);
      taken = in_valid && rdy0;
      @(negedge clk);
    end
    idle(TAPS + 3);
    total++;
    if (obs_q.size() != exp_q.size() || obs_q.size() < 20) begin
      bad++;
      $display("FAIL random_count: got %0d outputs, model %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      n++;
      if (o !== e) begin
        bad++;
        $display("FAIL random_value[%0d]: got %h required %h", n, o, e);
      end
    end
    total++;
    if (proto_err != pe0) begin
      bad++;
      $display("FAIL random_timing: got %0d deviations required 0", proto_err - pe0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_impulse("impulse");
    test_step();
    test_coef_load();
    test_coef_mid_mac();
    test_back_to_back();
    test_reset_mid_mac();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
